// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit and its byte queue.
package prefetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/prefetch_byte_queue.sv
// Circular byte store: appends bytes skip..3 of a fetched word, pops 0-4 head bytes per cycle
// and presents a zero-padded 4-byte head window.
module prefetch_byte_queue
  import prefetch_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            wr_en_i,
  input  logic [1:0]      wr_skip_i,
  input  logic [31:0]     wr_data_i,
  input  logic [2:0]      pop_count_i,
  output logic [CntW-1:0] count_o,
  output logic [31:0]     data_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] wr_num;
  logic [CntW-1:0] pop_num;
  logic [PtrW-1:0] wr_addr [WORD_BYTES];

  always_comb begin
    wr_num  = wr_en_i ? CntW'(WORD_BYTES - 32'(wr_skip_i)) : '0;
    pop_num = CntW'(pop_count_i);
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(pop_num);
      tail_d  = tail_q + PtrW'(wr_num);
      count_d = count_q + wr_num - pop_num;
    end
  end

  // Byte i of the word lands i-skip slots past the tail; skipped bytes are never written.
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      wr_addr[i] = tail_q + PtrW'(i) - PtrW'(wr_skip_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clear_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i >= int'(wr_skip_i)) begin
          mem_q[wr_addr[i]] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // Slots beyond the valid count read as zero, so stale storage never leaks out.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (CntW'(i) < count_q) begin
        data_o[8*i +: 8] = mem_q[head_q + PtrW'(i)];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue: issues aligned 32-bit code fetches, buffers the returned bytes
// and redirects on flush without ever withdrawing a bus request mid-handshake.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int unsigned QUEUE_BYTES   = 16,
  parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0,
  localparam int unsigned CntW = $clog2(QUEUE_BYTES) + 1
) (
  input  logic            i_clock,
  input  logic            i_reset,
  output logic            o_code_vaild,
  input  logic            i_code_ready,
  output logic [31:0]     o_code_address,
  input  logic [31:0]     i_code_data_read,
  input  logic            i_flush,
  input  logic [31:0]     i_flush_address,
  output logic [31:0]     o_queue_data,
  output logic [CntW-1:0] o_queue_count,
  output logic [31:0]     o_head_address,
  input  logic [2:0]      i_consume_count
);

  localparam logic [31:0] ResetFetch = {RESET_ADDRESS[31:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic            vaild_q, vaild_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [1:0]      skip_q, skip_d;
  logic [31:0]     head_addr_q, head_addr_d;
  logic            q_wr_en;
  logic            q_clear;
  logic [2:0]      q_pop;
  logic [CntW-1:0] queue_count;
  logic            space_ok;

  prefetch_byte_queue #(
    .Depth (QUEUE_BYTES)
  ) u_queue (
    .clk_i       (i_clock),
    .rst_i       (i_reset),
    .clear_i     (q_clear),
    .wr_en_i     (q_wr_en),
    .wr_skip_i   (skip_q),
    .wr_data_i   (i_code_data_read),
    .pop_count_i (q_pop),
    .count_o     (queue_count),
    .data_o      (o_queue_data)
  );

  // Only issue when a whole word is guaranteed to fit, even with zero consumption meanwhile.
  assign space_ok = (CntW'(QUEUE_BYTES) - queue_count) >= CntW'(WORD_BYTES);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!i_flush && space_ok) state_d = S_REQ;
      end
      S_REQ: begin
        if (i_code_ready) state_d = S_IDLE;
        else if (i_flush) state_d = S_DROP;
      end
      S_DROP: begin
        if (i_code_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vaild_d    = (state_d != S_IDLE);
    bus_addr_d = bus_addr_q;
    if (state_q == S_IDLE && state_d == S_REQ) bus_addr_d = fetch_addr_q;

    // A flush in the return cycle wins: the word belongs to the abandoned stream.
    q_wr_en = (state_q == S_REQ) && i_code_ready && !i_flush;
    q_clear = i_flush;
    q_pop   = i_flush ? 3'd0 : i_consume_count;

    fetch_addr_d = fetch_addr_q;
    skip_d       = skip_q;
    head_addr_d  = head_addr_q + 32'(q_pop);
    if (q_wr_en) begin
      fetch_addr_d = fetch_addr_q + 32'(WORD_BYTES);
      skip_d       = 2'd0;
    end
    if (i_flush) begin
      fetch_addr_d = {i_flush_address[31:2], 2'b00};
      skip_d       = i_flush_address[1:0];
      head_addr_d  = i_flush_address;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vaild_q      <= 1'b0;
      bus_addr_q   <= ResetFetch;
      fetch_addr_q <= ResetFetch;
      skip_q       <= RESET_ADDRESS[1:0];
      head_addr_q  <= RESET_ADDRESS;
    end else begin
      vaild_q      <= vaild_d;
      bus_addr_q   <= bus_addr_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
      head_addr_q  <= head_addr_d;
    end
  end

  assign o_code_vaild   = vaild_q;
  assign o_code_address = bus_addr_q;
  assign o_queue_count  = queue_count;
  assign o_head_address = head_addr_q;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed and randomized checks of prefetch_unit against a byte-queue reference model.
module tb_prefetch_unit;

  localparam int unsigned QB       = 16;
  localparam logic [31:0] RST_ADDR = 32'hFFFF_FFF0;
  localparam int unsigned CW       = $clog2(QB) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          code_vaild;
  logic          code_ready;
  logic [31:0]   code_address;
  logic [31:0]   code_data;
  logic          flush;
  logic [31:0]   flush_address;
  logic [31:0]   queue_data;
  logic [CW-1:0] queue_count;
  logic [31:0]   head_address;
  logic [2:0]    consume_count;

  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  // Reference model: bytes in flight as a queue, plus the bus/stream bookkeeping.
  logic [7:0]  mq[$];
  logic [31:0] m_head;
  logic [31:0] m_fetch;
  logic [31:0] m_bus;
  logic [1:0]  m_skip;
  bit          m_req;
  bit          m_drop;

  prefetch_unit #(
    .QUEUE_BYTES   (QB),
    .RESET_ADDRESS (RST_ADDR)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .o_code_vaild     (code_vaild),
    .i_code_ready     (code_ready),
    .o_code_address   (code_address),
    .i_code_data_read (code_data),
    .i_flush          (flush),
    .i_flush_address  (flush_address),
    .o_queue_data     (queue_data),
    .o_queue_count    (queue_count),
    .o_head_address   (head_address),
    .i_consume_count  (consume_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (rst || (CW'(consume_count) <= queue_count))
      else $error("illegal consume count %0d with %0d queued", consume_count, queue_count);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (%s): got %08h expected %08h", tag, phase, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < mq.size()) d[8*i +: 8] = mq[i];
    end
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_head  = RST_ADDR;
    m_fetch = RST_ADDR & ~32'h3;
    m_bus   = RST_ADDR & ~32'h3;
    m_skip  = RST_ADDR[1:0];
    m_req   = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic model_step(input bit fl, input logic [31:0] fa, input logic [2:0] cons,
                            input bit rdy, input logic [31:0] rd);
    bit issue;
    issue = !m_req && !fl && ((int'(QB) - mq.size()) >= 4);
    if (m_req && rdy) begin
      if (!m_drop && !fl) begin
        for (int i = int'(m_skip); i < 4; i++) mq.push_back(rd[8*i +: 8]);
        m_fetch = m_fetch + 32'd4;
        m_skip  = 2'd0;
      end
      m_req  = 1'b0;
      m_drop = 1'b0;
    end else if (m_req && fl) begin
      m_drop = 1'b1;
    end
    if (fl) begin
      mq.delete();
      m_head  = fa;
      m_fetch = fa & ~32'h3;
      m_skip  = fa[1:0];
    end else begin
      for (int i = 0; i < int'(cons); i++) void'(mq.pop_front());
      m_head = m_head + 32'(cons);
    end
    if (issue) begin
      m_req = 1'b1;
      m_bus = m_fetch;
    end
  endtask

  task automatic compare_all();
    check_eq("vaild", 32'(code_vaild), 32'(m_req));
    check_eq("addr", code_address, m_bus);
    check_eq("count", 32'(queue_count), 32'(mq.size()));
    check_eq("data", queue_data, exp_data());
    check_eq("head", head_address, m_head);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance model and DUT, then compare.
  task automatic cycle(input bit fl, input logic [31:0] fa, input logic [2:0] cons,
                       input bit rdy, input logic [31:0] rd);
    flush         = fl;
    flush_address = fa;
    consume_count = cons;
    code_ready    = rdy;
    code_data     = rd;
    model_step(fl, fa, cons, rdy, rd);
    @(posedge clk);
    @(negedge clk);
    flush         = 1'b0;
    consume_count = 3'd0;
    code_ready    = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 3'd0, 1'b0, '0);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!m_req && n < 8) begin
      idle(1);
      n++;
    end
    check_eq("req_seen", 32'(code_vaild), 32'd1);
  endtask

  task automatic fetch(input int delay, input logic [31:0] data, input logic [2:0] cons);
    wait_req();
    idle(delay);
    cycle(1'b0, '0, cons, 1'b1, data);
  endtask

  initial begin
    logic [31:0] h0;
    int          wait_cnt;
    rst           = 1'b0;
    flush         = 1'b0;
    flush_address = '0;
    consume_count = 3'd0;
    code_ready    = 1'b0;
    code_data     = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    phase = "reset";
    compare_all();
    rst = 1'b0;
    check_eq("rst_vaild", 32'(code_vaild), 32'd0);
    check_eq("rst_addr", code_address, 32'hFFFF_FFF0);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_data", queue_data, 32'd0);
    check_eq("rst_head", head_address, 32'hFFFF_FFF0);

    phase = "cold";
    idle(1);
    check_eq("cold_vaild", 32'(code_vaild), 32'd1);
    check_eq("cold_addr", code_address, 32'hFFFF_FFF0);
    fetch(2, 32'h4433_2211, 3'd0);
    check_eq("cold_count", 32'(queue_count), 32'd4);
    check_eq("cold_data", queue_data, 32'h4433_2211);
    check_eq("cold_head", head_address, 32'hFFFF_FFF0);
    idle(1);
    check_eq("cold_next", code_address, 32'hFFFF_FFF4);

    phase = "unaligned";
    fetch(0, $urandom(), 3'd0);
    cycle(1'b1, 32'h0000_1002, 3'd0, 1'b0, '0);
    idle(1);
    check_eq("ua_addr", code_address, 32'h0000_1000);
    fetch(0, 32'hDDCC_BBAA, 3'd0);
    check_eq("ua_count", 32'(queue_count), 32'd2);
    check_eq("ua_data", queue_data, 32'h0000_DDCC);
    check_eq("ua_head", head_address, 32'h0000_1002);
    idle(1);
    check_eq("ua_next", code_address, 32'h0000_1004);

    phase = "flush_outstanding";
    cycle(1'b1, 32'h0000_2000, 3'd0, 1'b0, '0);
    check_eq("fo_vaild", 32'(code_vaild), 32'd1);
    check_eq("fo_addr", code_address, 32'h0000_1004);
    idle(1);
    check_eq("fo_hold", code_address, 32'h0000_1004);
    cycle(1'b0, '0, 3'd0, 1'b1, 32'hFFFF_FFFF);
    check_eq("fo_count", 32'(queue_count), 32'd0);
    idle(1);
    check_eq("fo_vaild2", 32'(code_vaild), 32'd1);
    check_eq("fo_next", code_address, 32'h0000_2000);

    phase = "fill";
    for (int k = 0; k < 4; k++) fetch(1, $urandom(), 3'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_eq("full_quiet", 32'(code_vaild), 32'd0);
    end
    check_eq("full_count", 32'(queue_count), 32'd16);
    cycle(1'b0, '0, 3'd3, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_eq("space3_quiet", 32'(code_vaild), 32'd0);
    end
    cycle(1'b0, '0, 3'd1, 1'b0, '0);
    idle(1);
    check_eq("space4_req", 32'(code_vaild), 32'd1);
    check_eq("space4_addr", code_address, 32'h0000_2010);

    phase = "flush_ready";
    cycle(1'b1, 32'h0000_3001, 3'd0, 1'b1, $urandom());
    check_eq("fr_count", 32'(queue_count), 32'd0);
    check_eq("fr_vaild", 32'(code_vaild), 32'd0);
    idle(1);
    check_eq("fr_next", code_address, 32'h0000_3000);

    phase = "concurrent";
    fetch(0, $urandom(), 3'd0);
    fetch(0, $urandom(), 3'd0);
    repeat (3) fetch(0, $urandom(), 3'd4);
    cycle(1'b0, '0, 3'd2, 1'b0, '0);
    check_eq("cc_pre", 32'(queue_count), 32'd5);
    h0 = m_head;
    fetch(0, $urandom(), 3'd4);
    check_eq("cc_count", 32'(queue_count), 32'd5);
    check_eq("cc_head", head_address, h0 + 32'd4);

    phase = "reset_flush";
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h0000_0055, 3'd0, 1'b0, '0);
    check_eq("rf_head", head_address, 32'h0000_0055);
    idle(1);
    check_eq("rf_addr", code_address, 32'h0000_0054);
    fetch(0, $urandom(), 3'd0);
    check_eq("rf_count", 32'(queue_count), 32'd3);

    phase = "random";
    wait_cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      bit          fl;
      bit          rdy;
      logic [31:0] fa;
      logic [2:0]  cons;
      int          maxc;
      fl   = ($urandom_range(0, 31) == 0);
      fa   = $urandom();
      maxc = (mq.size() < 4) ? mq.size() : 4;
      cons = 3'($urandom_range(0, maxc));
      rdy  = 1'b0;
      if (m_req) begin
        if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          rdy      = 1'b1;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
      cycle(fl, fa, cons, rdy, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
